audio_event_arbiter: RTL
========================

AUDIO_EVENT_ARBITER -- requirements
Module: audio_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4: number of sound-event request channels (1..15).
REQ-002 SHALL have parameter MAX_PLAY, default 50_000_000: cycle timeout for one clip when play_done never arrives.
REQ-003 SHALL have parameter GAP_CYCLES, default 1024: silent cycles inserted between consecutive clips (0 allowed).
REQ-004 SHALL have parameter PREEMPT, default 1: 1 lets a higher-priority pending event abort the current clip; 0 never aborts.
REQ-005 SHALL have derived constant SEL_W = clog2(NUM_EVENTS+1).
REQ-006 clk  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 event_req  input  NUM_EVENTS  per-event request levels or pulses; bit 0 has highest priority.
REQ-009 play_done  input  1  single-cycle pulse from the audio player: the current clip has ended.
REQ-010 audio_select  output  SEL_W  0 = silence, k+1 = clip for event k; registered.
REQ-011 playing  output  1  high while in PLAY; registered.
REQ-012 dropped  output  1  one-cycle pulse when a request arrives for an event that is already pending.

Function
REQ-013 Pending latch: a rising edge on event_req[k] SHALL set pending[k]; pending[k] SHALL stay set until event k is launched.
REQ-014 Edge detection SHALL use a one-cycle registered copy of event_req, so a held level counts as one request.
REQ-015 A rising edge on an already-set pending[k] SHALL pulse dropped the next cycle and SHALL leave pending unchanged.
REQ-016 FSM states SHALL be IDLE, PLAY and GAP.
REQ-017 IDLE: if any pending bit is set, the next cycle SHALL enter PLAY with cur = lowest-index pending event, audio_select = cur+1 and pending[cur] cleared.
REQ-018 PLAY: a timer SHALL count from 0; on play_done or timer = MAX_PLAY-1, the FSM SHALL enter GAP (or IDLE if GAP_CYCLES=0) with audio_select = 0.
REQ-019 PLAY with PREEMPT=1: a pending event j < cur SHALL relaunch directly as in REQ-017, restarting the timer with no gap; the aborted event SHALL NOT be re-pended.
REQ-020 GAP: the FSM SHALL count GAP_CYCLES cycles with audio_select = 0, then enter IDLE.
REQ-021 Total latency from the request edge to audio_select changing SHALL be 2 cycles when idle.
REQ-022 play_done in IDLE or GAP SHALL be ignored.
REQ-023 Simultaneous edges on several bits SHALL all latch; launch SHALL follow priority order.
REQ-024 An edge arriving for event cur during its own PLAY SHALL set pending[cur], so the clip replays after the gap.
REQ-025 Timer and gap counters SHALL saturate and never wrap.

Reset
REQ-026 While reset_n = 0: audio_select = 0, playing = 0, dropped = 0, pending = 0, the event_req copy = 0, counters = 0 and state = IDLE, asynchronously.
REQ-027 Reset asserted mid-PLAY SHALL discard the current clip and all pending events.
REQ-028 After reset_n deasserts, a request input already high SHALL count as an edge on the first clock.

Structure
REQ-029 A shared package audio_pkg SHALL hold the state enum (IDLE/PLAY/GAP) and the SILENCE = 0 select constant.
REQ-030 A sub-module audio_edge_latch SHALL implement edge detection, the pending register and dropped generation; the FSM, timers and priority encoder SHALL stay in the top module.

Verification
REQ-031 Event 1 pulse from idle -> audio_select = 2 two cycles later; play_done -> 0 and GAP_CYCLES silent cycles.
REQ-032 Events 0 and 2 pulse in the same cycle -> select 1, then after play_done and the gap, select 3.
REQ-033 With PREEMPT=1, event 3 playing and event 0 pulsed -> select 1 within 2 cycles with no gap; with PREEMPT=0 -> select stays 4 until play_done.
REQ-034 No play_done with MAX_PLAY=100 -> select returns to 0 exactly 100 cycles after launch.
REQ-035 Event 2 pulsed twice while still pending -> one dropped pulse and one clip only.
REQ-036 reset_n low mid-PLAY with pending set -> all outputs 0 immediately; no clip after release unless a request input is high.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio event arbiter.
// Holds the arbiter state encoding and the silence select code.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int SILENCE = 0;

endpackage

// File: rtl/audio_edge_latch.sv
// Request edge detector and pending latch.
// Flags a repeat request for an event that is still waiting.
import audio_pkg::*;

module audio_edge_latch #(
    parameter int NUM_EVENTS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] event_req,
    input  logic [NUM_EVENTS-1:0] clear,
    output logic [NUM_EVENTS-1:0] pending,
    output logic                  dropped
);

    logic [NUM_EVENTS-1:0] req_q;
    logic [NUM_EVENTS-1:0] rise;

    assign rise = event_req & ~req_q;

    // Sample requests, latch new edges, flag edges that hit a waiting event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            req_q   <= event_req;
            pending <= (pending & ~clear) | rise;
            dropped <= |(rise & pending & ~clear);
        end
    end

endmodule

// File: rtl/audio_event_arbiter.sv
// Priority arbiter choosing which sound clip the player runs.
// Lowest pending index wins; clips are separated by a silent gap.
import audio_pkg::*;

module audio_event_arbiter #(
    parameter int NUM_EVENTS = 4,
    parameter int MAX_PLAY   = 50_000_000,
    parameter int GAP_CYCLES = 1024,
    parameter int PREEMPT    = 1,
    localparam int SEL_W     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] event_req,
    input  logic                  play_done,
    output logic [SEL_W-1:0]      audio_select,
    output logic                  playing,
    output logic                  dropped
);

    localparam int TW = $clog2(MAX_PLAY + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(MAX_PLAY - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(MAX_PLAY);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] G_MAX  = GW'(GAP_CYCLES);

    state_t                state, state_n;
    logic [SEL_W-1:0]      cur, cur_n;
    logic [TW-1:0]         timer, timer_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [SEL_W-1:0]      sel_q, sel_n;
    logic                  play_q, play_n;
    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] clear;
    logic [SEL_W-1:0]      enc;
    logic                  any_pend;
    logic                  launch;

    audio_edge_latch #(
        .NUM_EVENTS(NUM_EVENTS)
    ) u_latch (
        .clk      (clk),
        .reset_n  (reset_n),
        .event_req(event_req),
        .clear    (clear),
        .pending  (pending),
        .dropped  (dropped)
    );

    // Lowest-index pending event is the next candidate.
    always_comb begin
        enc = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending[i]) enc = SEL_W'(i);
        end
        any_pend = |pending;
    end

    // Next state, counters and registered outputs.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        timer_n = timer;
        gap_n   = gap_cnt;
        sel_n   = sel_q;
        play_n  = play_q;
        launch  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_pend) launch = 1'b1;
            end
            PLAY: begin
                timer_n = (timer == T_MAX) ? timer : timer + 1'b1;
                if (play_done || timer == T_LAST) begin
                    sel_n   = SEL_W'(SILENCE);
                    play_n  = 1'b0;
                    gap_n   = '0;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (PREEMPT != 0 && any_pend && enc < cur) begin
                    launch = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == G_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = (gap_cnt == G_MAX) ? gap_cnt : gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (launch) begin
            state_n = PLAY;
            cur_n   = enc;
            sel_n   = enc + SEL_W'(1);
            play_n  = 1'b1;
            timer_n = '0;
        end
    end

    // One-hot clear of the event being launched.
    always_comb begin
        clear = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            clear[i] = launch && (enc == SEL_W'(i));
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cur     <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            sel_q   <= '0;
            play_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            timer   <= timer_n;
            gap_cnt <= gap_n;
            sel_q   <= sel_n;
            play_q  <= play_n;
        end
    end

    assign audio_select = sel_q;
    assign playing      = play_q;

endmodule
